// File: rtl/border_pkg.sv
// border_pkg: border code encoding and detector FSM states shared by the
// background drawer and the border hit detectors.
package border_pkg;
   typedef logic [0:1] border_code_t;
   localparam border_code_t BORDER_NONE   = 2'b00;
   localparam border_code_t BORDER_SIDE   = 2'b10;
   localparam border_code_t BORDER_PLAYER = 2'b01;
   localparam border_code_t BORDER_STATS  = 2'b11;
   typedef enum logic [1:0] {WAIT_FRAME, SCAN, REPORT} border_hit_state_t;
endpackage

// File: rtl/border_hit_detector_if.sv
// border_hit_detector_if: border-flag bus from the background drawer (master)
// to a border hit detector (slave).
interface border_hit_detector_if #(parameter int PIXEL_WIDTH = 11);
   logic                     startOfFrame;
   logic [PIXEL_WIDTH-1:0]   pixelX;
   logic                     drawingRequest;
   border_pkg::border_code_t bordersDR;
   modport master (output startOfFrame, pixelX, drawingRequest, bordersDR);
   modport slave  (input  startOfFrame, pixelX, drawingRequest, bordersDR);
endinterface

// File: rtl/border_code_decoder.sv
// border_code_decoder: gates the border code with the object's drawing request
// and splits it into one-hot left/right/player-zone/stats strobes.
module border_code_decoder
   import border_pkg::*;
#(
   parameter int PIXEL_WIDTH = 11,
   parameter int X_MID       = 320
) (
   input  logic                   drawing_request,
   input  border_code_t           code,
   input  logic [PIXEL_WIDTH-1:0] pixel_x,
   output logic                   hit_left,
   output logic                   hit_right,
   output logic                   hit_player,
   output logic                   hit_stats
);
   logic side;
   logic active;
   assign active     = drawing_request && code != BORDER_NONE;
   assign side       = active && code == BORDER_SIDE;
   assign hit_left   = side && pixel_x <  PIXEL_WIDTH'(X_MID);
   assign hit_right  = side && pixel_x >= PIXEL_WIDTH'(X_MID);
   assign hit_player = active && code == BORDER_PLAYER;
   assign hit_stats  = active && code == BORDER_STATS;
endmodule

// File: rtl/border_hit_detector.sv
// border_hit_detector: accumulates border hits over a frame and publishes a
// registered report at the next frame start. BORDER_HIT_COUNT_EN adds per-type hit counters.
module border_hit_detector
   import border_pkg::*;
#(
   parameter int PIXEL_WIDTH = 11,
   parameter int X_MID       = 320,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   resetN,
   border_hit_detector_if.slave   bus,
   output logic                   hit_left,
   output logic                   hit_right,
   output logic                   hit_player_zone,
   output logic                   hit_stats_zone,
   output logic                   report_valid
`ifdef BORDER_HIT_COUNT_EN
   ,
   output logic [COUNT_WIDTH-1:0] cnt_left,
   output logic [COUNT_WIDTH-1:0] cnt_right,
   output logic [COUNT_WIDTH-1:0] cnt_player_zone,
   output logic [COUNT_WIDTH-1:0] cnt_stats_zone
`endif
);
   border_hit_state_t      state_q, state_d;
   logic [PIXEL_WIDTH-1:0] pixel_x_q, pixel_x_d;
   logic [3:0]             acc_q, acc_d, hit_q, hit_d, hits;
   logic                   valid_q, valid_d;
   logic                   idle, publish;

   // Bit order everywhere: {left, right, player zone, stats zone}.
   border_code_decoder #(.PIXEL_WIDTH(PIXEL_WIDTH), .X_MID(X_MID)) u_dec (
      .drawing_request (bus.drawingRequest),
      .code            (bus.bordersDR),
      .pixel_x         (pixel_x_q),
      .hit_left        (hits[3]),
      .hit_right       (hits[2]),
      .hit_player      (hits[1]),
      .hit_stats       (hits[0])
   );

   assign idle    = state_q == WAIT_FRAME;
   assign publish = !idle && bus.startOfFrame;

   always_comb begin
      pixel_x_d = bus.pixelX;
      state_d   = bus.startOfFrame ? (idle ? SCAN : REPORT) : (idle ? WAIT_FRAME : SCAN);
      acc_d     = idle ? (bus.startOfFrame ? 4'b0 : acc_q) : (bus.startOfFrame ? hits : acc_q | hits);
      hit_d     = publish ? acc_q : hit_q;
      valid_d   = publish;
   end

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state_q   <= WAIT_FRAME;
         pixel_x_q <= '0;
         acc_q     <= '0;
         hit_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pixel_x_q <= pixel_x_d;
         acc_q     <= acc_d;
         hit_q     <= hit_d;
         valid_q   <= valid_d;
      end

   assign {hit_left, hit_right, hit_player_zone, hit_stats_zone} = hit_q;
   assign report_valid = valid_q;

`ifdef BORDER_HIT_COUNT_EN
   logic [3:0][COUNT_WIDTH-1:0] cacc_q, cacc_d, cnt_q, cnt_d;

   // Counters follow the sticky bits' timing but saturate instead of wrapping.
   always_comb begin
      cnt_d = publish ? cacc_q : cnt_q;
      for (int i = 0; i < 4; i++)
         cacc_d[i] = idle ? (bus.startOfFrame ? '0 : cacc_q[i]) :
                     bus.startOfFrame ? COUNT_WIDTH'(hits[i]) :
                     &cacc_q[i] ? cacc_q[i] : cacc_q[i] + COUNT_WIDTH'(hits[i]);
   end

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         cacc_q <= '0;
         cnt_q  <= '0;
      end else begin
         cacc_q <= cacc_d;
         cnt_q  <= cnt_d;
      end

   assign {cnt_left, cnt_right, cnt_player_zone, cnt_stats_zone} = cnt_q;
`endif
endmodule

// File: tb/tb_border_hit_detector.sv
// tb_border_hit_detector: directed vectors with hand-computed reports.
// Counter checks run only when BORDER_HIT_COUNT_EN is defined.
module tb_border_hit_detector;
   import border_pkg::*;
   logic clk = 1'b0;
   logic resetN;
   logic hit_left, hit_right, hit_player_zone, hit_stats_zone, report_valid;
   int   n_run = 0, n_fail = 0;

   border_hit_detector_if #(.PIXEL_WIDTH(11)) bus ();

`ifdef BORDER_HIT_COUNT_EN
   logic [7:0] cnt_left, cnt_right, cnt_player_zone, cnt_stats_zone;
`endif

   border_hit_detector #(.PIXEL_WIDTH(11), .X_MID(320), .COUNT_WIDTH(8)) dut (
      .clk             (clk),
      .resetN          (resetN),
      .bus             (bus.slave),
      .hit_left        (hit_left),
      .hit_right       (hit_right),
      .hit_player_zone (hit_player_zone),
      .hit_stats_zone  (hit_stats_zone),
      .report_valid    (report_valid)
`ifdef BORDER_HIT_COUNT_EN
      ,
      .cnt_left        (cnt_left),
      .cnt_right       (cnt_right),
      .cnt_player_zone (cnt_player_zone),
      .cnt_stats_zone  (cnt_stats_zone)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs, then samples 1 time unit after the edge.
   task automatic cyc(input logic sof, input logic [10:0] px, input logic dr, input border_code_t bd);
      bus.startOfFrame   = sof;
      bus.pixelX         = px;
      bus.drawingRequest = dr;
      bus.bordersDR      = bd;
      @(posedge clk);
      #1;
   endtask

   // pixelX leads the request/code by one cycle.
   task automatic hit_at(input logic [10:0] px, input border_code_t bd);
      cyc(1'b0, px, 1'b0, BORDER_NONE);
      cyc(1'b0, 11'd0, 1'b1, bd);
   endtask

   function automatic logic [4:0] rpt();
      return {report_valid, hit_left, hit_right, hit_player_zone, hit_stats_zone};
   endfunction

   initial begin
      resetN = 1'b1;
      bus.startOfFrame = 1'b0; bus.pixelX = '0; bus.drawingRequest = 1'b0; bus.bordersDR = BORDER_NONE;
      #3 resetN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'(rpt()), 32'h0);
      resetN = 1'b1;

      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("first_sof_no_report", 32'(report_valid), 32'h0);
      hit_at(11'd20, BORDER_SIDE);
      hit_at(11'd25, BORDER_SIDE);
      cyc(1'b0, 11'd0, 1'b0, BORDER_NONE);
      chk("no_report_mid_frame", 32'(rpt()), 32'h0);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("left_report", 32'(rpt()), 32'b11000);
      cyc(1'b0, 11'd0, 1'b0, BORDER_NONE);
      chk("valid_one_cycle_hold", 32'(rpt()), 32'b01000);

      hit_at(11'd619, BORDER_SIDE);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("right_619", 32'(rpt()), 32'b10100);

      hit_at(11'd320, BORDER_SIDE);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("right_320", 32'(rpt()), 32'b10100);

      hit_at(11'd319, BORDER_SIDE);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("left_319", 32'(rpt()), 32'b11000);

      hit_at(11'd100, BORDER_STATS);
      cyc(1'b0, 11'd0, 1'b0, BORDER_PLAYER);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("stats_only_no_req", 32'(rpt()), 32'b10001);

      cyc(1'b0, 11'd50, 1'b0, BORDER_NONE);
      cyc(1'b1, 11'd0, 1'b1, BORDER_PLAYER);
      chk("coincident_excluded", 32'(rpt()), 32'b10000);
      cyc(1'b0, 11'd0, 1'b0, BORDER_NONE);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("coincident_next", 32'(rpt()), 32'b10010);

      hit_at(11'd20, BORDER_SIDE);
      #2 resetN = 1'b0;
      #1;
      chk("async_reset", 32'(rpt()), 32'h0);
      @(posedge clk);
      #1 resetN = 1'b1;
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("post_reset_sof_no_report", 32'(report_valid), 32'h0);
      cyc(1'b0, 11'd0, 1'b0, BORDER_NONE);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("post_reset_zero_report", 32'(rpt()), 32'b10000);

      hit_at(11'd20, BORDER_SIDE);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("b2b_first", 32'(rpt()), 32'b11000);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("b2b_second", 32'(rpt()), 32'b10000);
      cyc(1'b0, 11'd0, 1'b0, BORDER_NONE);
      chk("b2b_done", 32'(report_valid), 32'h0);

`ifdef BORDER_HIT_COUNT_EN
      hit_at(11'd30, BORDER_SIDE);
      repeat (300) cyc(1'b0, 11'd0, 1'b1, BORDER_PLAYER);
      cyc(1'b1, 11'd0, 1'b1, BORDER_PLAYER);
      chk("cnt_pz_saturate", 32'(cnt_player_zone), 32'd255);
      chk("cnt_left_one", 32'(cnt_left), 32'd1);
      chk("cnt_right_zero", 32'(cnt_right), 32'd0);
      cyc(1'b1, 11'd0, 1'b0, BORDER_NONE);
      chk("cnt_pz_seeded", 32'(cnt_player_zone), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
